// File: rtl/ejemplo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ejemplo_pkg
// Description : Shared widths, types and helpers for the ejemplo pair unit.
// Revision    : 1.0  initial release
// ============================================================================
package ejemplo_pkg;

  localparam int OP_W      = 2;
  localparam int SUM_W     = OP_W + 1;
  localparam int CNT_W_DEF = 8;

  typedef logic [OP_W-1:0]  op_t;
  typedef logic [SUM_W-1:0] sum_t;

  // Zero-extend both operands before adding so the carry lands in the MSB.
  function automatic sum_t add_zext(input op_t x, input op_t y);
    return sum_t'(x) + sum_t'(y);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ejemplo_pair_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : ejemplo_pair_unit_if
// Description : Operand/result bundle of the pair unit.
//               master : drives a, b; observes all results.
//               slave  : samples a, b; drives sum, and_o, or_o, xor_o,
//                        eq, gt, lt, chg_cnt, valid.
// Revision    : 1.0  initial release
// ============================================================================
interface ejemplo_pair_unit_if
  import ejemplo_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);

  op_t              a;
  op_t              b;
  sum_t             sum;
  op_t              and_o;
  op_t              or_o;
  op_t              xor_o;
  logic             eq;
  logic             gt;
  logic             lt;
  logic [CNT_W-1:0] chg_cnt;
  logic             valid;

  modport master (
    output a, b,
    input  sum, and_o, or_o, xor_o, eq, gt, lt, chg_cnt, valid
  );

  modport slave (
    input  a, b,
    output sum, and_o, or_o, xor_o, eq, gt, lt, chg_cnt, valid
  );

endinterface
`default_nettype wire

// File: rtl/ejemplo_cmp2.sv
`default_nettype none
// ============================================================================
// Module      : ejemplo_cmp2
// Description : Combinational unsigned magnitude comparator.
//               a, b   : operands
//               eq     : a == b
//               gt     : a >  b
//               lt     : a <  b
// Revision    : 1.0  initial release
// ============================================================================
module ejemplo_cmp2
  import ejemplo_pkg::*;
(
  input  op_t  a,
  input  op_t  b,
  output logic eq,
  output logic gt,
  output logic lt
);

  assign eq = (a == b);
  assign gt = (a >  b);
  assign lt = (a <  b);

endmodule
`default_nettype wire

// File: rtl/ejemplo_pair_unit.sv
`default_nettype none
// ============================================================================
// Module      : ejemplo_pair_unit
// Description : Registered 2-bit operand pair evaluator: sum, bitwise logic,
//               magnitude compare and a saturating count of operand changes.
//               clk  : rising-edge clock
//               rst  : asynchronous active-high reset
//               bus  : operand inputs and registered results (slave side)
// Revision    : 1.0  initial release
// ============================================================================
module ejemplo_pair_unit
  import ejemplo_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
)(
  input  wire logic          clk,
  input  wire logic          rst,
  ejemplo_pair_unit_if.slave bus
);

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  logic             w_eq;
  logic             w_gt;
  logic             w_lt;
  logic             w_changed;

  sum_t             r_sum;
  op_t              r_and;
  op_t              r_or;
  op_t              r_xor;
  logic             r_eq;
  logic             r_gt;
  logic             r_lt;
  logic [CNT_W-1:0] r_chg_cnt;
  logic             r_valid;
  logic [3:0]       r_prev;

  ejemplo_cmp2 u_cmp (
    .a  (bus.a),
    .b  (bus.b),
    .eq (w_eq),
    .gt (w_gt),
    .lt (w_lt)
  );

  // r_valid gates the comparison so the first sample after reset is never
  // counted against the cleared prev register.
  assign w_changed = r_valid && ({bus.a, bus.b} != r_prev);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum     <= '0;
      r_and     <= '0;
      r_or      <= '0;
      r_xor     <= '0;
      r_eq      <= 1'b0;
      r_gt      <= 1'b0;
      r_lt      <= 1'b0;
      r_chg_cnt <= '0;
      r_valid   <= 1'b0;
      r_prev    <= '0;
    end else begin
      r_sum   <= add_zext(bus.a, bus.b);
      r_and   <= bus.a & bus.b;
      r_or    <= bus.a | bus.b;
      r_xor   <= bus.a ^ bus.b;
      r_eq    <= w_eq;
      r_gt    <= w_gt;
      r_lt    <= w_lt;
      r_valid <= 1'b1;
      r_prev  <= {bus.a, bus.b};
      if (w_changed && (r_chg_cnt != c_cnt_max)) begin
        r_chg_cnt <= r_chg_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.sum     = r_sum;
  assign bus.and_o   = r_and;
  assign bus.or_o    = r_or;
  assign bus.xor_o   = r_xor;
  assign bus.eq      = r_eq;
  assign bus.gt      = r_gt;
  assign bus.lt      = r_lt;
  assign bus.chg_cnt = r_chg_cnt;
  assign bus.valid   = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_ejemplo_pair_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ejemplo_pair_unit
// Description : Scoreboard bench for ejemplo_pair_unit. u_dut0 uses the
//               default counter width, u_dut1 uses CNT_W=2 for saturation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ejemplo_pair_unit;

  typedef struct packed {
    logic [2:0]  sum;
    logic [1:0]  and_v;
    logic [1:0]  or_v;
    logic [1:0]  xor_v;
    logic        eq;
    logic        gt;
    logic        lt;
    logic [15:0] cnt;
  } exp_t;

  logic clk  = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;

  int checks   = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];

  ejemplo_pair_unit_if #(.CNT_W(8)) if0 ();
  ejemplo_pair_unit_if #(.CNT_W(2)) if1 ();

  ejemplo_pair_unit #(.CNT_W(8)) u_dut0 (.clk(clk), .rst(rst0), .bus(if0));
  ejemplo_pair_unit #(.CNT_W(2)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1));

  always #5 clk = ~clk;

  function automatic exp_t mk(input int s, input int an, input int o, input int x,
                              input int e, input int g, input int l, input int c);
    exp_t r;
    r.sum = 3'(s); r.and_v = 2'(an); r.or_v = 2'(o); r.xor_v = 2'(x);
    r.eq = 1'(e); r.gt = 1'(g); r.lt = 1'(l); r.cnt = 16'(c);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Drive one operand pair and queue the response expected after the next edge.
  task automatic apply(input int sel, input logic [1:0] a, input logic [1:0] b, input exp_t e);
    if (sel == 0) begin
      if0.a = a; if0.b = b; q0.push_back(e);
    end else begin
      if1.a = a; if1.b = b; q1.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t act0();
    return {if0.sum, if0.and_o, if0.or_o, if0.xor_o, if0.eq, if0.gt, if0.lt, 16'(if0.chg_cnt)};
  endfunction

  function automatic exp_t act1();
    return {if1.sum, if1.and_o, if1.or_o, if1.xor_o, if1.eq, if1.gt, if1.lt, 16'(if1.chg_cnt)};
  endfunction

  // Monitors: whenever a DUT presents valid results and a response is owed, compare.
  always @(negedge clk) begin
    if (if0.valid === 1'b1 && q0.size() > 0) begin
      exp_t e;
      e = q0.pop_front();
      chk("dut0_result", 32'(act0()), 32'(e));
    end
  end

  always @(negedge clk) begin
    if (if1.valid === 1'b1 && q1.size() > 0) begin
      exp_t e;
      e = q1.pop_front();
      chk("dut1_result", 32'(act1()), 32'(e));
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    if0.a = 2'b00; if0.b = 2'b00;
    if1.a = 2'b00; if1.b = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state0", 32'({act0(), if0.valid}), 32'd0);
    chk("reset_state1", 32'({act1(), if1.valid}), 32'd0);

    // Release reset just after an edge; the next edge is the first sample.
    @(posedge clk); #1;
    rst0 = 1'b0;
    for (int i = 0; i < 5; i++) apply(0, 2'b00, 2'b00, mk(0, 0, 0, 0, 1, 0, 0, 0));
    apply(0, 2'b10, 2'b00, mk(2, 0, 2, 2, 0, 1, 0, 1));
    for (int i = 0; i < 3; i++) apply(0, 2'b11, 2'b11, mk(6, 3, 3, 0, 1, 0, 0, 2));
    apply(0, 2'b01, 2'b10, mk(3, 0, 3, 3, 0, 0, 1, 3));

    // Mid-cycle asynchronous reset, checked before the next edge.
    @(negedge clk);
    #2 rst0 = 1'b1;
    #1 chk("async_reset0", 32'({act0(), if0.valid}), 32'd0);

    @(posedge clk); #1;
    rst0 = 1'b0;
    apply(0, 2'b11, 2'b01, mk(4, 1, 3, 2, 0, 1, 0, 0));
    apply(0, 2'b11, 2'b01, mk(4, 1, 3, 2, 0, 1, 0, 0));
    apply(0, 2'b00, 2'b11, mk(3, 0, 3, 3, 0, 0, 1, 1));

    // Narrow counter: toggle b each cycle to reach saturation.
    rst1 = 1'b0;
    apply(1, 2'b00, 2'b00, mk(0, 0, 0, 0, 1, 0, 0, 0));
    apply(1, 2'b00, 2'b01, mk(1, 0, 1, 1, 0, 0, 1, 1));
    apply(1, 2'b00, 2'b00, mk(0, 0, 0, 0, 1, 0, 0, 2));
    apply(1, 2'b00, 2'b01, mk(1, 0, 1, 1, 0, 0, 1, 3));
    apply(1, 2'b00, 2'b00, mk(0, 0, 0, 0, 1, 0, 0, 3));
    apply(1, 2'b00, 2'b01, mk(1, 0, 1, 1, 0, 0, 1, 3));
    @(negedge clk);
    #2 rst1 = 1'b1;
    #1 chk("sat_reset_cnt", 32'({if1.chg_cnt, if1.valid}), 32'd0);

    repeat (2) @(negedge clk);
    #1;
    chk("queue0_drained", 32'(q0.size()), 32'd0);
    chk("queue1_drained", 32'(q1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
